alu32: RTL and testbench
========================

// Module: alu32
// PURPOSE
//   Integer ALU for the datapath: combinational result from two operands and a
//   3-bit opcode (add, sub, and, or, xor, slt, sll, srl). Status flags for the
//   current operation are captured in a register each clock for later
//   condition evaluation by the control logic.
// PARAMETERS
//   WIDTH  32  operand/result width; power of two, >= 8
// PORTS
//   clk            in   1      clock; flag register updates on rising edge
//   rst            in   1      asynchronous, active-high reset
//   operand_a      in   WIDTH  first operand (minuend / shift source)
//   operand_b      in   WIDTH  second operand (subtrahend / shift amount)
//   alu_opcode     in   3      operation select
//   result         out  WIDTH  combinational result
//   flag_zero      out  1      registered: result == 0
//   flag_negative  out  1      registered: result[WIDTH-1]
//   flag_carry     out  1      registered carry (see below)
//   flag_overflow  out  1      registered signed overflow
// BEHAVIOUR
//   - One clock; reset asynchronous, active-high.
//   - result is purely combinational, zero latency; not affected by rst/clk.
//   - Opcodes:
//       000 ADD  a+b, modulo 2^WIDTH
//       001 SUB  a-b, modulo 2^WIDTH (two's complement a + ~b + 1)
//       010 AND  a&b   011 OR a|b   100 XOR a^b
//       101 SLT  1 if signed(a) < signed(b), else 0 (zero-extended)
//       110 SLL  a << b[log2(WIDTH)-1:0], zero fill
//       111 SRL  a >> b[log2(WIDTH)-1:0], logical, zero fill
//     Upper bits of b above the shift field are ignored; shift by 0 passes a.
//   - Flags computed combinationally from current inputs, registered on every
//     rising clk edge (no enable); outputs reflect the previous cycle's op.
//   - flag_carry: ADD = carry-out of bit WIDTH-1; SUB = 1 when no borrow
//     (unsigned a >= b); all other ops 0.
//   - flag_overflow: ADD = operands same sign, result sign differs; SUB =
//     operand signs differ, result sign differs from a; all other ops 0.
//   - flag_zero / flag_negative derived from result for every opcode.
//   - rst asserted: all four flags clear to 0 immediately; held while rst=1.
//     Deassertion mid-stream: first rising edge after release captures flags.
//   - No X propagation from defined inputs; all opcodes fully decoded.
// TESTING
//   ADD AAAAAABB+11223344 -> result BBCCDDFF; next edge carry=0 ovf=0 zero=0 neg=1
//   SUB 11223344-AAAAAABB -> 66778889; carry=0 (borrow), ovf=0, neg=0
//   AAAAAAAA,55555555: AND -> 00000000 (zero=1); OR -> FFFFFFFF; XOR -> FFFFFFFF
//   ADD 7FFFFFFF+00000001 -> 80000000, ovf=1; ADD FFFFFFFF+1 -> 0, carry=1 zero=1
//   SLT 80000000,00000001 -> 1; SLL 00000001,00000024 -> 00000010; SRL 80000000,1F -> 1
//   Assert rst between clock edges with flags set -> all flags 0 at once; result unchanged

Source files
------------

// File: rtl/alu32.sv
// Integer ALU: combinational result for eight opcodes, with zero/negative/
// carry/overflow status captured in a register on every clock edge.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_negative,
  output logic             flag_carry,
  output logic             flag_overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  logic             is_add;
  logic             is_sub;
  logic             use_sub_path;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf_raw;
  logic             signed_less;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sll_val;
  logic [WIDTH-1:0] srl_val;
  logic             zero_next;
  logic             negative_next;
  logic             carry_next;
  logic             overflow_next;

  assign is_add       = (alu_opcode == OP_ADD);
  assign is_sub       = (alu_opcode == OP_SUB);
  // SLT reuses the subtractor: less-than is the true sign of a-b
  assign use_sub_path = is_sub || (alu_opcode == OP_SLT);

  // Shared adder: a + b, or a + ~b + 1 for subtraction and compare
  assign b_eff     = use_sub_path ? ~operand_b : operand_b;
  assign sum_ext   = {1'b0, operand_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub_path};
  assign sum       = sum_ext[WIDTH-1:0];
  assign carry_out = sum_ext[WIDTH];

  assign ovf_raw     = (operand_a[MSB] == b_eff[MSB]) && (sum[MSB] != operand_a[MSB]);
  assign signed_less = sum[MSB] ^ ovf_raw;

  // Upper bits of operand_b beyond the shift field are intentionally ignored
  assign shamt = operand_b[SHW-1:0];

  always_comb begin
    sll_val = operand_a;
    for (int i = 0; i < SHW; i++) begin
      if (shamt[i]) begin
        sll_val = sll_val << (1 << i);
      end
    end
  end

  always_comb begin
    srl_val = operand_a;
    for (int i = 0; i < SHW; i++) begin
      if (shamt[i]) begin
        srl_val = srl_val >> (1 << i);
      end
    end
  end

  always_comb begin
    result = '0;
    case (alu_opcode)
      OP_ADD:  result = sum;
      OP_SUB:  result = sum;
      OP_AND:  result = operand_a & operand_b;
      OP_OR:   result = operand_a | operand_b;
      OP_XOR:  result = operand_a ^ operand_b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, signed_less};
      OP_SLL:  result = sll_val;
      OP_SRL:  result = srl_val;
      default: result = '0;
    endcase
  end

  // Carry on SUB is the inverted borrow, i.e. the raw adder carry-out
  always_comb begin
    zero_next     = (result == '0);
    negative_next = result[MSB];
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    if (is_add || is_sub) begin
      carry_next    = carry_out;
      overflow_next = ovf_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
    end else begin
      flag_zero     <= zero_next;
      flag_negative <= negative_next;
      flag_carry    <= carry_next;
      flag_overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Bench for alu32: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results and flags, and a reset test.
module tb_alu32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [2:0]  alu_opcode;
  logic [31:0] result;
  logic        flag_zero;
  logic        flag_negative;
  logic        flag_carry;
  logic        flag_overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [3:0] exp_flags;

  alu32 #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .alu_opcode    (alu_opcode),
    .result        (result),
    .flag_zero     (flag_zero),
    .flag_negative (flag_negative),
    .flag_carry    (flag_carry),
    .flag_overflow (flag_overflow)
  );

  always #5 clk = ~clk;

  function automatic longint to_signed(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sh1_0000_0000 : longint'(v);
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] op);
    longint unsigned ua = a;
    longint unsigned ub = b;
    int sh = int'(b % 32);
    case (op)
      3'd0: return 32'((ua + ub) % 64'h1_0000_0000);
      3'd1: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (to_signed(a) < to_signed(b)) ? 32'd1 : 32'd0;
      3'd6: return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
      default: return 32'(ua / (64'd1 << sh));
    endcase
  endfunction

  // {zero, negative, carry, overflow}
  function automatic logic [3:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    logic [31:0] r = model_result(a, b, op);
    longint sa = to_signed(a);
    longint sb = to_signed(b);
    longint lim_hi = 64'sd2147483647;
    longint lim_lo = -64'sd2147483648;
    logic c = 1'b0;
    logic v = 1'b0;
    if (op == 3'd0) begin
      c = (longint'(a) + longint'(b)) > 64'sh0_FFFF_FFFF;
      v = (sa + sb > lim_hi) || (sa + sb < lim_lo);
    end else if (op == 3'd1) begin
      c = (a >= b);
      v = (sa - sb > lim_hi) || (sa - sb < lim_lo);
    end
    return {r == 32'd0, r[31], c, v};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) exp_flags <= 4'd0;
    else     exp_flags <= model_flags(operand_a, operand_b, alu_opcode);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (a=%08h b=%08h op=%0d) t=%0t",
               name, actual, expected, operand_a, operand_b, alu_opcode, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_result", result, model_result(operand_a, operand_b, alu_opcode));
      check("model_flags", {28'd0, flag_zero, flag_negative, flag_carry, flag_overflow},
            {28'd0, exp_flags});
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[$];

  task automatic apply(input vec_t v);
    @(posedge clk);
    #2;
    operand_a  = v.a;
    operand_b  = v.b;
    alu_opcode = v.op;
    #1;
    check("vec_result", result, v.r);
    @(posedge clk);
    #1;
    check("vec_flags", {28'd0, flag_zero, flag_negative, flag_carry, flag_overflow},
          {28'd0, v.f});
  endtask

  initial begin
    rst        = 1'b1;
    operand_a  = 32'd0;
    operand_b  = 32'd0;
    alu_opcode = 3'd0;

    // flags {zero, negative, carry, overflow}, all hand-computed
    vecs.push_back('{32'hAAAAAABB, 32'h11223344, 3'd0, 32'hBBCCDDFF, 4'b0100});
    vecs.push_back('{32'h11223344, 32'hAAAAAABB, 3'd1, 32'h66778889, 4'b0000});
    vecs.push_back('{32'hAAAAAAAA, 32'h55555555, 3'd2, 32'h00000000, 4'b1000});
    vecs.push_back('{32'hAAAAAAAA, 32'h55555555, 3'd3, 32'hFFFFFFFF, 4'b0100});
    vecs.push_back('{32'hAAAAAAAA, 32'h55555555, 3'd4, 32'hFFFFFFFF, 4'b0100});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 3'd0, 32'h80000000, 4'b0101});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 4'b1010});
    vecs.push_back('{32'h80000000, 32'h00000001, 3'd5, 32'h00000001, 4'b0000});
    vecs.push_back('{32'h00000001, 32'h00000024, 3'd6, 32'h00000010, 4'b0000});
    vecs.push_back('{32'h80000000, 32'h0000001F, 3'd7, 32'h00000001, 4'b0000});
    vecs.push_back('{32'h00000005, 32'h00000005, 3'd1, 32'h00000000, 4'b1010});
    vecs.push_back('{32'h80000000, 32'h00000001, 3'd1, 32'h7FFFFFFF, 4'b0011});
    vecs.push_back('{32'h00000001, 32'h80000000, 3'd5, 32'h00000000, 4'b1000});
    vecs.push_back('{32'h12345678, 32'hFFFFFFE0, 3'd6, 32'h12345678, 4'b0000});
    vecs.push_back('{32'hF0000000, 32'h00000004, 3'd7, 32'h0F000000, 4'b0000});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 3'd5, 32'h00000001, 4'b0000});
    vecs.push_back('{32'h00000003, 32'h00000007, 3'd1, 32'hFFFFFFFC, 4'b0100});

    #12;
    check("reset_flags", {28'd0, flag_zero, flag_negative, flag_carry, flag_overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset between edges with zero and carry set: flags clear at once
    apply('{32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 4'b1010});
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_flags", {28'd0, flag_zero, flag_negative, flag_carry, flag_overflow}, 32'd0);
    check("rst_result", result, 32'h00000000);
    @(posedge clk);
    #1;
    check("rst_held_flags", {28'd0, flag_zero, flag_negative, flag_carry, flag_overflow}, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("rst_release_flags", {28'd0, flag_zero, flag_negative, flag_carry, flag_overflow}, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_capture", {28'd0, flag_zero, flag_negative, flag_carry, flag_overflow},
          32'h0000000A);

    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      operand_a  = $urandom;
      operand_b  = (i % 4 == 0) ? operand_a : $urandom;
      alu_opcode = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
